// File: rtl/dram_cmd_gen.sv
// DDR4 command generator: decodes one request at a time into ACT/PRE/RD/WR under an
// open-page policy, pacing commands on DRAM-clock ticks (every second CPU_clock cycle).
module dram_cmd_gen #(
   parameter int T_RCD   = 24,
   parameter int T_RP    = 24,
   parameter int T_RAS   = 52,
   parameter int T_CL    = 24,
   parameter int T_CWL   = 20,
   parameter int T_BURST = 4
) (
   input  logic        CPU_clock,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [1:0]  req_opcode,
   input  logic [32:0] req_address,
   output logic        req_ready,
   output logic        cmd_valid,
   output logic [2:0]  cmd_type,
   output logic [1:0]  cmd_bg,
   output logic [1:0]  cmd_bank,
   output logic [14:0] cmd_row,
   output logic [7:0]  cmd_col,
   output logic        done,
   output logic        page_hit
);
   // state      | meaning
   // IDLE       | ready for a request
   // DECIDE     | compare request with the bank's open row
   // PRE        | wait for tRAS, then precharge
   // WAIT_RP    | precharge recovery; ACT issues on the last tick
   // ACT        | activate on the next tick
   // WAIT_RCD   | activate-to-column delay; RD/WR issues on the last tick
   // RW         | column command on the next tick
   // WAIT_DATA  | read/write latency plus burst
   // DONE       | one-cycle completion pulse
   typedef enum logic [3:0] {
      S_IDLE, S_DECIDE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_RW, S_WAIT_DATA, S_DONE
   } state_t;

   localparam logic [2:0] CMD_NOP = 3'd0, CMD_ACT = 3'd1, CMD_RD = 3'd2,
                          CMD_WR = 3'd3, CMD_PRE = 3'd4;
   localparam logic [6:0] RCD_W = 7'(T_RCD);
   localparam logic [6:0] RP_W  = 7'(T_RP);
   localparam logic [6:0] RAS_W = 7'(T_RAS);
   localparam logic [6:0] RDL_W = 7'(T_CL + T_BURST);
   localparam logic [6:0] WRL_W = 7'(T_CWL + T_BURST);

   state_t      state_q, state_d;
   logic        phase_q;
   logic        wr_q, wr_d, hit_q, hit_d;
   logic [14:0] row_q, row_d;
   logic [7:0]  col_q, col_d;
   logic [3:0]  bidx_q, bidx_d;
   logic [6:0]  wait_q, wait_d;
   logic [15:0] open_q, open_d;
   logic [14:0] open_row_q [16];
   logic [14:0] open_row_d [16];
   logic [6:0]  ras_q [16];
   logic [6:0]  ras_d [16];
   logic        cmd_valid_q, cmd_valid_d;
   logic [2:0]  cmd_type_q, cmd_type_d;
   logic [1:0]  cmd_bg_q, cmd_bg_d, cmd_bank_q, cmd_bank_d;
   logic [14:0] cmd_row_q, cmd_row_d;
   logic [7:0]  cmd_col_q, cmd_col_d;

   logic tick, accept, bank_open, row_match, ras_ok, wait_end;
   logic issue_pre, issue_act, issue_rw;
   logic addr_unused;

   assign addr_unused = ^req_address[5:0];
   assign tick      = phase_q;
   assign req_ready = (state_q == S_IDLE) && !rst;
   assign accept    = req_valid && req_ready;
   assign bank_open = open_q[bidx_q];
   assign row_match = (open_row_q[bidx_q] == row_q);
   assign ras_ok    = (ras_q[bidx_q] >= RAS_W);
   // a zero-valued timing parameter behaves like a single tick
   assign wait_end  = (wait_q <= 7'd1);

   assign issue_pre = tick && (state_q == S_PRE) && ras_ok;
   assign issue_act = tick && ((state_q == S_ACT) || ((state_q == S_WAIT_RP) && wait_end));
   assign issue_rw  = tick && ((state_q == S_RW) || ((state_q == S_WAIT_RCD) && wait_end));

   always_ff @(posedge CPU_clock) begin
      if (rst) begin
         state_q     <= S_IDLE;
         phase_q     <= 1'b0;
         wr_q        <= 1'b0;
         hit_q       <= 1'b0;
         row_q       <= '0;
         col_q       <= '0;
         bidx_q      <= '0;
         wait_q      <= '0;
         open_q      <= '0;
         cmd_valid_q <= 1'b0;
         cmd_type_q  <= CMD_NOP;
         cmd_bg_q    <= '0;
         cmd_bank_q  <= '0;
         cmd_row_q   <= '0;
         cmd_col_q   <= '0;
         for (int i = 0; i < 16; i++) begin
            open_row_q[i] <= '0;
            ras_q[i]      <= '0;
         end
      end else begin
         state_q     <= state_d;
         phase_q     <= ~phase_q;
         wr_q        <= wr_d;
         hit_q       <= hit_d;
         row_q       <= row_d;
         col_q       <= col_d;
         bidx_q      <= bidx_d;
         wait_q      <= wait_d;
         open_q      <= open_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_type_q  <= cmd_type_d;
         cmd_bg_q    <= cmd_bg_d;
         cmd_bank_q  <= cmd_bank_d;
         cmd_row_q   <= cmd_row_d;
         cmd_col_q   <= cmd_col_d;
         for (int i = 0; i < 16; i++) begin
            open_row_q[i] <= open_row_d[i];
            ras_q[i]      <= ras_d[i];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (accept) state_d = S_DECIDE;
         S_DECIDE: begin
            if (bank_open && row_match) state_d = S_RW;
            else if (!bank_open)        state_d = S_ACT;
            else                        state_d = S_PRE;
         end
         S_PRE:       if (issue_pre) state_d = S_WAIT_RP;
         S_WAIT_RP:   if (issue_act) state_d = S_WAIT_RCD;
         S_ACT:       if (issue_act) state_d = S_WAIT_RCD;
         S_WAIT_RCD:  if (issue_rw) state_d = S_WAIT_DATA;
         S_RW:        if (issue_rw) state_d = S_WAIT_DATA;
         S_WAIT_DATA: if (tick && wait_end) state_d = S_DONE;
         S_DONE:      state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   always_comb begin
      wr_d   = wr_q;
      row_d  = row_q;
      col_d  = col_q;
      bidx_d = bidx_q;
      if (accept) begin
         wr_d   = (req_opcode == 2'd1);
         row_d  = req_address[32:18];
         col_d  = req_address[17:10];
         bidx_d = {req_address[7:6], req_address[9:8]};
      end
      hit_d = hit_q;
      if (state_q == S_DECIDE) hit_d = bank_open && row_match;

      cmd_valid_d = 1'b0;
      cmd_type_d  = CMD_NOP;
      cmd_bg_d    = cmd_bg_q;
      cmd_bank_d  = cmd_bank_q;
      cmd_row_d   = cmd_row_q;
      cmd_col_d   = cmd_col_q;
      if (issue_pre || issue_act || issue_rw) begin
         cmd_valid_d = 1'b1;
         cmd_bg_d    = bidx_q[3:2];
         cmd_bank_d  = bidx_q[1:0];
         cmd_row_d   = row_q;
         cmd_col_d   = col_q;
      end
      if (issue_pre) cmd_type_d = CMD_PRE;
      if (issue_act) cmd_type_d = CMD_ACT;
      if (issue_rw)  cmd_type_d = wr_q ? CMD_WR : CMD_RD;

      wait_d = wait_q;
      if (tick && (state_q == S_WAIT_RP || state_q == S_WAIT_RCD || state_q == S_WAIT_DATA))
         wait_d = wait_q - 7'd1;
      if (issue_pre) wait_d = RP_W;
      if (issue_act) wait_d = RCD_W;
      if (issue_rw)  wait_d = wr_q ? WRL_W : RDL_W;

      open_d = open_q;
      for (int i = 0; i < 16; i++) begin
         open_row_d[i] = open_row_q[i];
         ras_d[i]      = ras_q[i];
         if (tick && ras_q[i] != 7'h7F) ras_d[i] = ras_q[i] + 7'd1;
      end
      if (issue_pre) open_d[bidx_q] = 1'b0;
      if (issue_act) begin
         open_d[bidx_q]     = 1'b1;
         open_row_d[bidx_q] = row_q;
         ras_d[bidx_q]      = '0;
      end
   end

   assign cmd_valid = cmd_valid_q;
   assign cmd_type  = cmd_type_q;
   assign cmd_bg    = cmd_bg_q;
   assign cmd_bank  = cmd_bank_q;
   assign cmd_row   = cmd_row_q;
   assign cmd_col   = cmd_col_q;
   assign done      = (state_q == S_DONE);
   assign page_hit  = (state_q == S_DONE) && hit_q;

endmodule

// File: tb/tb_dram_cmd_gen.sv
// Bench for dram_cmd_gen: a tick-schedule model predicts every command, done pulse and
// ready window per cycle; directed test-plan cases plus randomized request traffic.
module tb_dram_cmd_gen;
   localparam int T_RCD = 24, T_RP = 24, T_RAS = 52, T_CL = 24, T_CWL = 20, T_BURST = 4;

   logic        CPU_clock = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic [1:0]  req_opcode = '0;
   logic [32:0] req_address = '0;
   logic        req_ready, cmd_valid, done, page_hit;
   logic [2:0]  cmd_type;
   logic [1:0]  cmd_bg, cmd_bank;
   logic [14:0] cmd_row;
   logic [7:0]  cmd_col;

   always #5 CPU_clock = ~CPU_clock;

   dram_cmd_gen #(.T_RCD(T_RCD), .T_RP(T_RP), .T_RAS(T_RAS), .T_CL(T_CL),
                  .T_CWL(T_CWL), .T_BURST(T_BURST)) dut (
      .CPU_clock(CPU_clock), .rst(rst), .req_valid(req_valid), .req_opcode(req_opcode),
      .req_address(req_address), .req_ready(req_ready), .cmd_valid(cmd_valid),
      .cmd_type(cmd_type), .cmd_bg(cmd_bg), .cmd_bank(cmd_bank), .cmd_row(cmd_row),
      .cmd_col(cmd_col), .done(done), .page_hit(page_hit));

   int n_checks = 0, n_fail = 0;
   int cyc = 0, n_acc = 0, acc_e = -1;
   bit started = 0, ph = 0;
   int ready_from = 0, done_cyc = -1;
   bit exp_hit = 0;
   bit          b_open [16];
   logic [14:0] b_row [16];
   int          b_act [16];
   logic [2:0]  e_type [int];
   logic [14:0] e_row [int];
   logic [7:0]  e_col [int];
   logic [1:0]  e_bg [int];
   logic [1:0]  e_bank [int];
   logic [1:0]  last_bg = '0, last_bank = '0;
   int obs_act = -1, obs_pre = -1, obs_rw = -1, obs_done = -1;
   bit obs_hit = 0;

   task automatic check(input bit ok, input string nm, input longint got, input longint exp);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, got, exp);
      end
   endtask

   function automatic void add_evt(input int c, input logic [2:0] t, input logic [32:0] a);
      e_type[c] = t;
      e_row[c]  = a[32:18];
      e_col[c]  = a[17:10];
      e_bg[c]   = a[7:6];
      e_bank[c] = a[9:8];
   endfunction

   // Tick cycles have phase 1; a decision made in tick t shows on the outputs in cycle t+1.
   function automatic void schedule(input logic [1:0] op, input logic [32:0] a, input int e);
      int idx, ft, p, x, r, w;
      bit hit;
      idx = int'({a[7:6], a[9:8]});
      ft  = (ph == 1'b0) ? e + 1 : e + 2;
      hit = b_open[idx] && (b_row[idx] == a[32:18]);
      if (hit) r = ft;
      else begin
         if (b_open[idx]) begin
            p = ft;
            if (b_act[idx] + 2 * (T_RAS + 1) > p) p = b_act[idx] + 2 * (T_RAS + 1);
            add_evt(p + 1, 3'd4, a);
            x = p + 2 * T_RP;
         end else x = ft;
         add_evt(x + 1, 3'd1, a);
         b_open[idx] = 1'b1;
         b_row[idx]  = a[32:18];
         b_act[idx]  = x;
         r = x + 2 * T_RCD;
      end
      w = (op == 2'd1) ? T_CWL + T_BURST : T_CL + T_BURST;
      add_evt(r + 1, (op == 2'd1) ? 3'd3 : 3'd2, a);
      done_cyc   = r + 2 * w + 1;
      exp_hit    = hit;
      ready_from = done_cyc + 1;
      acc_e      = e;
   endfunction

   always @(posedge CPU_clock) begin
      if (rst) begin
         cyc++;
         ph = 1'b0;
         started = 1'b1;
         for (int i = 0; i < 16; i++) b_open[i] = 1'b0;
         e_type.delete(); e_row.delete(); e_col.delete(); e_bg.delete(); e_bank.delete();
         done_cyc = -1;
         ready_from = cyc;
         last_bg = '0;
         last_bank = '0;
      end else begin
         bit acc;
         acc = started && req_valid && (cyc >= ready_from);
         cyc++;
         ph = ~ph;
         if (acc) begin
            schedule(req_opcode, req_address, cyc);
            n_acc++;
         end
      end
   end

   always @(negedge CPU_clock) begin
      if (started) begin
         if (e_type.exists(cyc)) begin
            check(cmd_valid === 1'b1, "cmd_valid_on_cmd", cmd_valid, 1);
            check(cmd_type === e_type[cyc], "cmd_type", cmd_type, e_type[cyc]);
            check(cmd_bg === e_bg[cyc], "cmd_bg", cmd_bg, e_bg[cyc]);
            check(cmd_bank === e_bank[cyc], "cmd_bank", cmd_bank, e_bank[cyc]);
            if (e_type[cyc] == 3'd1) check(cmd_row === e_row[cyc], "cmd_row", cmd_row, e_row[cyc]);
            if (e_type[cyc] == 3'd2 || e_type[cyc] == 3'd3)
               check(cmd_col === e_col[cyc], "cmd_col", cmd_col, e_col[cyc]);
            last_bg = e_bg[cyc];
            last_bank = e_bank[cyc];
         end else begin
            check(cmd_valid === 1'b0, "cmd_valid_idle", cmd_valid, 0);
            check(cmd_type === 3'd0, "cmd_type_nop", cmd_type, 0);
            check(cmd_bg === last_bg, "cmd_bg_hold", cmd_bg, last_bg);
            check(cmd_bank === last_bank, "cmd_bank_hold", cmd_bank, last_bank);
         end
         check(done === (cyc == done_cyc), "done", done, cyc == done_cyc);
         check(page_hit === ((cyc == done_cyc) && exp_hit), "page_hit", page_hit,
               (cyc == done_cyc) && exp_hit);
         check(req_ready === (!rst && cyc >= ready_from), "req_ready", req_ready,
               !rst && cyc >= ready_from);
         if (cmd_valid === 1'b1) begin
            if (cmd_type == 3'd1) obs_act = cyc;
            if (cmd_type == 3'd2 || cmd_type == 3'd3) obs_rw = cyc;
            if (cmd_type == 3'd4) obs_pre = cyc;
         end
         if (done === 1'b1) begin
            obs_done = cyc;
            obs_hit  = page_hit;
         end
      end
   end

   function automatic logic [32:0] mk_addr(input int row, input int col, input int bidx);
      logic [32:0] a;
      a = {15'(row), 8'(col), 2'(bidx), 2'(bidx >> 2), 6'($urandom)};
      return a;
   endfunction

   task automatic clr_obs();
      obs_act = -1; obs_pre = -1; obs_rw = -1; obs_done = -1; obs_hit = 0;
   endtask

   task automatic send(input logic [1:0] op, input logic [32:0] a, input bit keep);
      int n0;
      bit got;
      n0 = n_acc;
      got = 0;
      req_valid = 1'b1;
      req_opcode = op;
      req_address = a;
      for (int i = 0; i < 2000 && !got; i++) begin
         @(posedge CPU_clock); #1;
         if (n_acc != n0) got = 1;
      end
      if (!got) check(1'b0, "accept_timeout", 0, 1);
      if (!keep) req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int i = 0; i < 3000 && !ok; i++) begin
         if (cyc >= ready_from) ok = 1;
         else begin @(posedge CPU_clock); #1; end
      end
      if (!ok) check(1'b0, "idle_timeout", cyc, ready_from);
   endtask

   initial begin
      int t1_act, done_a;
      logic [32:0] a;
      repeat (3) @(posedge CPU_clock);
      #1 rst = 1'b0;

      clr_obs();
      send(2'd0, 33'h0_0004_0400, 0);
      wait_idle();
      t1_act = obs_act;
      check(obs_rw - obs_act == 48, "t1_act_to_rd", obs_rw - obs_act, 48);
      check(obs_done - obs_rw == 56, "t1_rd_to_done", obs_done - obs_rw, 56);
      check(obs_hit == 0, "t1_page_hit", obs_hit, 0);

      clr_obs();
      send(2'd1, 33'h0_0004_0400, 0);
      wait_idle();
      check(obs_act == -1, "t2_no_act", obs_act, -1);
      check(obs_done - obs_rw == 48, "t2_wr_to_done", obs_done - obs_rw, 48);
      check(obs_hit == 1, "t2_page_hit", obs_hit, 1);

      clr_obs();
      send(2'd2, 33'h0_0004_03C0, 0);
      wait_idle();
      check(obs_act != -1, "t4_bank15_act", obs_act, 1);
      clr_obs();
      send(2'd0, 33'h0_0004_0400, 0);
      wait_idle();
      check(obs_hit == 1, "t4_bank0_still_open", obs_hit, 1);

      clr_obs();
      send(2'd0, 33'h0_0008_0400, 0);
      wait_idle();
      check(obs_pre - t1_act >= 2 * T_RAS, "t3_ras_min", obs_pre - t1_act, 2 * T_RAS);
      check(obs_act - obs_pre == 48, "t3_pre_to_act", obs_act - obs_pre, 48);
      check(obs_rw - obs_act == 48, "t3_act_to_rd", obs_rw - obs_act, 48);

      clr_obs();
      send(2'd1, mk_addr(3, 9, 5), 0);
      wait_idle();
      t1_act = obs_act;
      clr_obs();
      send(2'd3, mk_addr(4, 9, 5), 0);
      wait_idle();
      check(obs_pre - t1_act >= 2 * T_RAS, "ras_hold", obs_pre - t1_act, 2 * T_RAS);
      check(obs_hit == 0, "reserved_op_served", obs_hit, 0);

      clr_obs();
      send(2'd0, mk_addr(7, 3, 3), 0);
      repeat (20) @(posedge CPU_clock);
      #1 rst = 1'b1;
      repeat (2) @(posedge CPU_clock);
      #1 rst = 1'b0;
      repeat (80) @(posedge CPU_clock);
      #1;
      check(obs_done == -1, "abort_no_done", obs_done, -1);
      clr_obs();
      send(2'd0, 33'h0_0004_0400, 0);
      wait_idle();
      check(obs_act != -1, "post_reset_act", obs_act, 1);
      check(obs_hit == 0, "post_reset_miss", obs_hit, 0);

      send(2'd0, 33'h0_0004_0400, 1);
      done_a = done_cyc;
      req_opcode = 2'd1;
      req_address = 33'h0_000C_0800;
      send(2'd1, 33'h0_000C_0800, 0);
      check(acc_e >= done_a + 2, "held_no_early_accept", acc_e, done_a + 2);
      wait_idle();

      for (int k = 0; k < 100; k++) begin
         bit hold;
         int bidx;
         bidx = ($urandom_range(0, 4) == 0) ? 15 : int'($urandom_range(0, 3));
         a = mk_addr(int'($urandom_range(1, 3)), int'($urandom_range(0, 255)), bidx);
         hold = ($urandom_range(0, 3) == 0);
         send(2'($urandom_range(0, 3)), a, hold);
         if (!hold) repeat ($urandom_range(0, 3)) @(posedge CPU_clock);
         #1;
      end
      req_valid = 1'b0;
      wait_idle();
      repeat (4) @(posedge CPU_clock);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
